// File: rtl/dcache_tb_pkg.sv
// Shared types and constants for the Dcache CPU-side traffic generator.
package dcache_tb_pkg;

  // Run sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_RWAIT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Galois feedback mask for the 32-bit data generator
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Run modes: write/read pairs, or all writes followed by all reads
  localparam int MODE_INTERLEAVED = 0;
  localparam int MODE_BULK        = 1;

  // One right-shifting Galois step: feed back the taps when bit 0 falls out
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    logic [31:0] shifted;
    shifted = {1'b0, cur[31:1]};
    if (cur[0]) begin
      return shifted ^ LFSR_TAPS;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// 32-bit Galois LFSR with synchronous reseed; one instance produces write
// data, another regenerates the same sequence to check read data.
module lfsr_gen
  import dcache_tb_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [31:0] state
);

  // Hold, reseed, or advance the sequence by one step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/dcache_test_driver.sv
// CPU-side traffic generator and checker for the Dcache data port. Writes an
// LFSR data pattern over an address range, reads it back, and reports the
// error count, first failing address and read timeouts.
module dcache_test_driver
  import dcache_tb_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                NUM_WORDS   = 16,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = {ADDR_W{1'b0}},
  parameter int                ADDR_STRIDE = 4,
  parameter int                MODE        = 0,
  parameter logic [31:0]       LFSR_SEED   = 32'h0000_0001,
  parameter int                TIMEOUT     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  ram_stall_i,
  input  logic                  ram_rvalid_i,
  input  logic [DATA_W-1:0]     ram_data_i,
  output logic [ADDR_W-1:0]     ram_raddr_o,
  output logic [ADDR_W-1:0]     ram_waddr_o,
  output logic [DATA_W-1:0]     ram_data_o,
  output logic                  ram_we_o,
  output logic                  ram_re_o,
  output logic [DATA_W/8-1:0]   ram_sel_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [15:0]           err_count_o,
  output logic [ADDR_W-1:0]     first_err_addr_o
);

  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(ADDR_STRIDE);
  localparam logic [15:0]       LAST_IDX  = 16'(NUM_WORDS - 1);
  localparam logic [31:0]       TMO_LIMIT = 32'(TIMEOUT - 1);

  // LFSR words are 32 bits; narrower buses take the low bits, wider ones
  // are zero-extended.
  function automatic logic [DATA_W-1:0] to_data(input logic [31:0] v);
    return DATA_W'({{DATA_W{1'b0}}, v});
  endfunction

  state_t              state;
  logic [15:0]         idx;
  logic [ADDR_W-1:0]   addr;
  logic [31:0]         tcount;
  logic [31:0]         wr_state;
  logic [31:0]         chk_state;

  logic                start_ok;
  logic                wr_step;
  logic                chk_step;
  logic                last;
  logic                mismatch;
  logic [DATA_W-1:0]   exp_data;
  logic [15:0]         err_next;

  assign start_ok = start_i && ((state == ST_IDLE) || (state == ST_DONE));
  assign wr_step  = (state == ST_WR) && ram_we_o && !ram_stall_i;
  assign chk_step = (state == ST_RWAIT) && ram_rvalid_i;
  assign last     = (idx == LAST_IDX);
  // The check LFSR sits one step behind the word being read
  assign exp_data = to_data(lfsr_next(chk_state));
  assign mismatch = chk_step && (ram_data_i != exp_data);
  assign err_next = (err_count_o == 16'hFFFF) ? err_count_o : err_count_o + 16'd1;

  lfsr_gen #(.SEED(LFSR_SEED)) u_wr_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_ok),
    .step  (wr_step),
    .state (wr_state)
  );

  lfsr_gen #(.SEED(LFSR_SEED)) u_chk_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_ok),
    .step  (chk_step),
    .state (chk_state)
  );

  // Run sequencer: issues one request at a time, checks read data, and owns
  // every registered output. A request strobe is raised one cycle after
  // entering WR/RD and dropped the cycle after it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      idx              <= 16'd0;
      addr             <= {ADDR_W{1'b0}};
      tcount           <= 32'd0;
      ram_raddr_o      <= {ADDR_W{1'b0}};
      ram_waddr_o      <= {ADDR_W{1'b0}};
      ram_data_o       <= {DATA_W{1'b0}};
      ram_we_o         <= 1'b0;
      ram_re_o         <= 1'b0;
      ram_sel_o        <= {(DATA_W/8){1'b0}};
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      timeout_o        <= 1'b0;
      err_count_o      <= 16'd0;
      first_err_addr_o <= {ADDR_W{1'b0}};
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state            <= ST_WR;
            idx              <= 16'd0;
            addr             <= ADDR_BASE;
            tcount           <= 32'd0;
            ram_we_o         <= 1'b0;
            ram_re_o         <= 1'b0;
            ram_sel_o        <= {(DATA_W/8){1'b1}};
            busy_o           <= 1'b1;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            timeout_o        <= 1'b0;
            err_count_o      <= 16'd0;
            first_err_addr_o <= {ADDR_W{1'b0}};
          end
        end

        ST_WR: begin
          if (!ram_we_o) begin
            ram_we_o    <= 1'b1;
            ram_waddr_o <= addr;
            ram_data_o  <= to_data(lfsr_next(wr_state));
          end else if (!ram_stall_i) begin
            ram_we_o <= 1'b0;
            if (MODE == MODE_BULK) begin
              if (last) begin
                idx   <= 16'd0;
                addr  <= ADDR_BASE;
                state <= ST_RD;
              end else begin
                idx  <= idx + 16'd1;
                addr <= addr + STRIDE;
              end
            end else begin
              state <= ST_RD;
            end
          end
        end

        ST_RD: begin
          if (!ram_re_o) begin
            ram_re_o    <= 1'b1;
            ram_raddr_o <= addr;
          end else if (!ram_stall_i) begin
            ram_re_o <= 1'b0;
            tcount   <= 32'd0;
            state    <= ST_RWAIT;
          end
        end

        ST_RWAIT: begin
          if (ram_rvalid_i) begin
            if (mismatch) begin
              err_count_o <= err_next;
              if (err_count_o == 16'd0) begin
                first_err_addr_o <= addr;
              end
            end
            if (last) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
              pass_o <= (err_count_o == 16'd0) && !mismatch;
            end else begin
              idx   <= idx + 16'd1;
              addr  <= addr + STRIDE;
              state <= (MODE == MODE_BULK) ? ST_RD : ST_WR;
            end
          end else if (tcount == TMO_LIMIT) begin
            timeout_o <= 1'b1;
            state     <= ST_DONE;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            pass_o    <= 1'b0;
          end else begin
            tcount <= tcount + 32'd1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          ram_we_o <= 1'b0;
          ram_re_o <= 1'b0;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule
